pc_unit: RTL and testbench

Parametrised program-counter unit and successor to the single-word PC register. It holds the PC and advances it by a configurable step each enabled cycle. It also supports absolute load (jump/branch), call/return through an internal circular return-address stack (RAS), and stall. The PC is driven onto the shared instruction-address bus through a tri-state output. It sits between the control unit and the instruction memory.

---
 rtl/pc_unit.sv | 130 +++++++++++++
 tb/tb_pc_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter with step/jump/call/return and a circular return-address stack.
// Latency: the new PC and RAS flags are visible in the cycle after the action edge.
// Backpressure: none. i_stall or i_cs=0 holds all state for the cycle.
module pc_unit #(
  parameter int                    WORD_SIZE    = 32,
  parameter logic [WORD_SIZE-1:0]  RESET_VECTOR = '0,
  parameter logic [WORD_SIZE-1:0]  PC_STEP      = WORD_SIZE'(4),
  parameter int                    RAS_DEPTH    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cs,
  input  logic                 i_oe,
  input  logic                 i_stall,
  input  logic                 i_load,
  input  logic                 i_call,
  input  logic                 i_ret,
  input  logic [WORD_SIZE-1:0] i_load_addr,
  output logic [WORD_SIZE-1:0] o_pc,
  output logic                 o_ras_empty,
  output logic                 o_ras_full,
  output logic                 o_ras_err
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  // Architectural state
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 err_q, err_d;

  // Return-address storage; contents are don't-care after reset
  logic [WORD_SIZE-1:0] ras_q [RAS_DEPTH];

  // RAS write port, driven by the next-state logic
  logic                 ras_we;
  logic [PTR_W-1:0]     ras_waddr;
  logic [WORD_SIZE-1:0] ras_wdat;

  // Derived values
  logic [WORD_SIZE-1:0] pc_inc;
  logic [PTR_W-1:0]     top_idx;
  logic [WORD_SIZE-1:0] ras_top;
  logic                 ras_empty;
  logic                 ras_full;

  assign pc_inc    = pc_q + PC_STEP;
  assign top_idx   = ptr_q - PTR_W'(1);
  assign ras_top   = ras_q[top_idx];
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));

  // Next-state: stall > call+ret swap > ret > call > load > sequential step
  always_comb begin
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    err_d     = err_q;
    ras_we    = 1'b0;
    ras_waddr = ptr_q;
    ras_wdat  = pc_inc;

    if (i_cs && !i_stall) begin
      if (i_call && i_ret && !ras_empty) begin
        // Tail swap: replace the top entry in place, depth unchanged
        ras_we    = 1'b1;
        ras_waddr = top_idx;
        pc_d      = i_load_addr;
      end else if (i_ret && !i_call) begin
        if (!ras_empty) begin
          pc_d  = ras_top;
          cnt_d = cnt_q - CNT_W'(1);
          ptr_d = top_idx;
        end else begin
          // Underflow: keep fetching sequentially and flag it
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end else if (i_call) begin
        // Plain push (also the call+ret case on an empty stack).
        // When full, ptr_q already points at the oldest entry, so the
        // write naturally overwrites it.
        ras_we    = 1'b1;
        ras_waddr = ptr_q;
        ptr_d     = ptr_q + PTR_W'(1);
        pc_d      = i_load_addr;
        if (ras_full) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (i_load) begin
        pc_d = i_load_addr;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // PC, stack pointer, count and sticky error register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  // RAS entry write; entries need no reset since count gates every read
  always_ff @(posedge i_clk) begin
    if (ras_we) begin
      ras_q[ras_waddr] <= ras_wdat;
    end
  end

  // Shared instruction-address bus driver
  assign o_pc        = (i_cs && i_oe) ? pc_q : {WORD_SIZE{1'bz}};
  assign o_ras_empty = ras_empty;
  assign o_ras_full  = ras_full;
  assign o_ras_err   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_cs = 1'b1, i_oe = 1'b1, i_stall = 1'b0;
  logic        i_load = 1'b0, i_call = 1'b0, i_ret = 1'b0;
  logic [31:0] i_load_addr = '0;
  wire  [31:0] o_pc;
  logic        o_ras_empty, o_ras_full, o_ras_err;

  pc_unit #(
    .WORD_SIZE   (32),
    .RESET_VECTOR(32'h100),
    .PC_STEP     (32'd4),
    .RAS_DEPTH   (4)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_cs       (i_cs),
    .i_oe       (i_oe),
    .i_stall    (i_stall),
    .i_load     (i_load),
    .i_call     (i_call),
    .i_ret      (i_ret),
    .i_load_addr(i_load_addr),
    .o_pc       (o_pc),
    .o_ras_empty(o_ras_empty),
    .o_ras_full (o_ras_full),
    .o_ras_err  (o_ras_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    bit          z;
    bit          emp;
    bit          full;
    bit          err;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: pops every pending expectation shortly after it is posted
  initial begin
    exp_t        e;
    logic [31:0] zval;
    zval = {32{1'bz}};
    forever begin
      @(chk_ev);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (e.z) begin
          if (o_pc !== zval) begin
            n_bad++;
            $display("FAIL %s o_pc: got %h want %h", e.name, o_pc, zval);
          end
        end else if (o_pc !== e.pc) begin
          n_bad++;
          $display("FAIL %s o_pc: got %h want %h", e.name, o_pc, e.pc);
        end
        n_cmp++;
        if (o_ras_empty !== e.emp) begin
          n_bad++;
          $display("FAIL %s empty: got %b want %b", e.name, o_ras_empty, e.emp);
        end
        n_cmp++;
        if (o_ras_full !== e.full) begin
          n_bad++;
          $display("FAIL %s full: got %b want %b", e.name, o_ras_full, e.full);
        end
        n_cmp++;
        if (o_ras_err !== e.err) begin
          n_bad++;
          $display("FAIL %s err: got %b want %b", e.name, o_ras_err, e.err);
        end
      end
    end
  end

  // Apply controls away from the edge, then move just past the next rising edge
  task automatic drive(input bit cs, input bit oe, input bit stall, input bit ld,
                       input bit call, input bit ret, input logic [31:0] a);
    i_cs = cs; i_oe = oe; i_stall = stall;
    i_load = ld; i_call = call; i_ret = ret; i_load_addr = a;
    @(posedge i_clk);
    #1;
  endtask

  // Post an expectation for the monitor, then land between edges
  task automatic chk(input string n, input logic [31:0] pc, input bit z,
                     input bit emp, input bit full, input bit err);
    exp_t e;
    e.name = n; e.pc = pc; e.z = z; e.emp = emp; e.full = full; e.err = err;
    q.push_back(e);
    -> chk_ev;
    #4;
  endtask

  // Raise reset mid-cycle and check the state without any clock edge
  task automatic do_reset(input string n);
    @(negedge i_clk);
    #1;
    i_cs = 1'b1; i_oe = 1'b1;
    i_stall = 1'b0; i_load = 1'b0; i_call = 1'b0; i_ret = 1'b0;
    i_rst = 1'b1;
    #1;
    chk(n, 32'h100, 0, 1, 0, 0);
    i_rst = 1'b0;
  endtask

  // Shorthands for common controls with cs=oe=1
  task automatic step(input string n, input logic [31:0] pc, input bit emp,
                      input bit full, input bit err);
    drive(1, 1, 0, 0, 0, 0, 32'h0);
    chk(n, pc, 0, emp, full, err);
  endtask

  initial begin
    // 1: reset, sequential stepping, asynchronous mid-run reset
    do_reset("reset_state");
    step("seq1", 32'h104, 1, 0, 0);
    step("seq2", 32'h108, 1, 0, 0);
    step("seq3", 32'h10C, 1, 0, 0);
    step("seq4", 32'h110, 1, 0, 0);
    do_reset("async_reset");

    // 2: single call/return
    drive(1, 1, 0, 1, 0, 0, 32'h200); chk("load_200", 32'h200, 0, 1, 0, 0);
    drive(1, 1, 0, 0, 1, 0, 32'h800); chk("call_800", 32'h800, 0, 0, 0, 0);
    step("inc_804", 32'h804, 0, 0, 0);
    step("inc_808", 32'h808, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 1, 32'h0);   chk("ret_204", 32'h204, 0, 1, 0, 0);

    // 3: overflow of a 4-deep RAS, then drain and underflow
    drive(1, 1, 0, 1, 0, 0, 32'h0);   chk("load_0", 32'h0, 0, 1, 0, 0);
    drive(1, 1, 0, 0, 1, 0, 32'h10);  chk("call1", 32'h10, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 1, 0, 32'h20);  chk("call2", 32'h20, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 1, 0, 32'h30);  chk("call3", 32'h30, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 1, 0, 32'h40);  chk("call4_full", 32'h40, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 1, 0, 32'h50);  chk("call5_ovf", 32'h50, 0, 0, 1, 1);
    drive(1, 1, 0, 0, 0, 1, 32'h0);   chk("ret1", 32'h44, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 1, 32'h0);   chk("ret2", 32'h34, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 1, 32'h0);   chk("ret3", 32'h24, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 1, 32'h0);   chk("ret4", 32'h14, 0, 1, 0, 1);
    drive(1, 1, 0, 0, 0, 1, 32'h0);   chk("ret5_unf", 32'h18, 0, 1, 0, 1);
    do_reset("reset_clears_err");

    // 4: stall, deselect, output disable
    drive(1, 1, 0, 0, 1, 0, 32'h300); chk("call_300", 32'h300, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 1, 0, 32'h900); chk("stall_call", 32'h300, 0, 0, 0, 0);
    end
    drive(0, 1, 0, 0, 1, 0, 32'h900); chk("cs0_a", 32'h0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 32'h0);   chk("cs0_b", 32'h0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 32'h0);   chk("oe0_a", 32'h0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 32'h0);   chk("oe0_b", 32'h0, 1, 0, 0, 0);
    step("oe1_30c", 32'h30C, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 1, 32'h0);   chk("ret_104", 32'h104, 0, 1, 0, 0);

    // 5: PC wrap and sticky underflow flag
    drive(1, 1, 0, 1, 0, 0, 32'hFFFF_FFFC); chk("load_top", 32'hFFFF_FFFC, 0, 1, 0, 0);
    step("wrap_0", 32'h0, 1, 0, 0);
    drive(1, 1, 0, 0, 0, 1, 32'h0);   chk("ret_empty", 32'h4, 0, 1, 0, 1);
    step("sticky1", 32'h8, 1, 0, 1);
    drive(1, 1, 0, 1, 0, 0, 32'h60);  chk("sticky_load", 32'h60, 0, 1, 0, 1);
    do_reset("reset_clears_err2");

    // 6: tail swap, load vs ret priority, swap on empty stack
    drive(1, 1, 0, 1, 0, 0, 32'h4C);  chk("load_4c", 32'h4C, 0, 1, 0, 0);
    drive(1, 1, 0, 0, 1, 0, 32'h90);  chk("call_90", 32'h90, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 1, 1, 32'hA00); chk("swap", 32'hA00, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 0, 1, 32'hB00); chk("load_ret", 32'h94, 0, 1, 0, 0);
    drive(1, 1, 0, 0, 1, 1, 32'hC00); chk("swap_empty", 32'hC00, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 1, 32'h0);   chk("ret_98", 32'h98, 0, 1, 0, 0);

    #20;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
